mem_access_ctrl: RTL

- MEM-stage data-memory access controller. Sits at the consuming end of the EX/MEM pipeline register.
- Turns the registered MEM-stage load/store controls into a valid/ready request on the data-memory bus and collects the load response.
- Aligns and sign-extends load data for write-back.
- Stalls the pipeline until each access completes.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/load_store_align.sv | 51 +++++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_DM  = 2'd1;
  localparam logic [1:0] WDSEL_PC4 = 2'd2;
  localparam logic [1:0] WDSEL_EXT = 2'd3;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // funct3[1] selects word; otherwise funct3[0] picks half over byte.
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    return funct3[1] ? SIZE_W : {1'b0, funct3[0]};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store data replication/strobes and load extract/extend.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_size_i)
      SIZE_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_addr_lo_i;
      end
      SIZE_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_size_i)
      SIZE_B:  ld_data_o = {{24{ld_byte[7] & ~ld_unsigned_i}}, ld_byte};
      SIZE_H:  ld_data_o = {{16{ld_half[15] & ~ld_unsigned_i}}, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: valid/ready request issue, load
// response collection with timeout, and pipeline stall generation.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_inst,
  input  logic [1:0]  MEM_wdsel,
  input  logic        MEM_rfwe,
  input  logic        MEM_dmwe,
  input  logic [31:0] MEM_aluc,
  input  logic [31:0] MEM_rfrD2,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic        dm_req_we,
  output logic [31:0] dm_req_addr,
  output logic [31:0] dm_req_wdata,
  output logic [3:0]  dm_req_wstrb,
  input  logic        dm_rsp_valid,
  input  logic [31:0] dm_rsp_rdata,
  output logic        mem_stall,
  output logic [31:0] MEM_rdo,
  output logic        mem_misalign,
  output logic        mem_buserr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic        is_load, is_store, access, misaligned, go;
  logic [1:0]  size;
  logic [31:0] lane_wdata, ld_data;
  logic [3:0]  lane_wstrb;
  logic        unused_inst;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, we_q, uns_q, buserr_q;
  logic [31:0]      addr_q, wdata_q, rdo_q;
  logic [3:0]       wstrb_q;
  logic [1:0]       size_q, lo_q;

  // Store has priority when both a store and a memory write-back are flagged.
  assign is_store   = MEM_dmwe;
  assign is_load    = MEM_rfwe && (MEM_wdsel == WDSEL_DM) && !MEM_dmwe;
  assign access     = is_load || is_store;
  assign size       = size_of(MEM_inst[14:12]);
  assign misaligned = is_misaligned(size, MEM_aluc[1:0]);
  assign go         = access && !misaligned;

  assign mem_stall    = go && (state_q != DONE);
  assign mem_misalign = access && misaligned;
  assign unused_inst  = ^{MEM_inst[31:15], MEM_inst[11:0]};

  load_store_align u_align (
    .st_size_i     (size),
    .st_addr_lo_i  (MEM_aluc[1:0]),
    .st_data_i     (MEM_rfrD2),
    .st_wdata_o    (lane_wdata),
    .st_wstrb_o    (lane_wstrb),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_addr_lo_i  (lo_q),
    .ld_rdata_i    (dm_rsp_rdata),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      size_q   <= SIZE_B;
      uns_q    <= 1'b0;
      lo_q     <= '0;
      rdo_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      buserr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            we_q    <= is_store;
            addr_q  <= {MEM_aluc[31:2], 2'b00};
            wdata_q <= lane_wdata;
            wstrb_q <= is_store ? lane_wstrb : 4'b0000;
            size_q  <= size;
            uns_q   <= MEM_inst[14];
            lo_q    <= MEM_aluc[1:0];
            valid_q <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (dm_req_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= we_q ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A response on the last counted cycle still wins over the timeout.
          if (dm_rsp_valid) begin
            rdo_q   <= ld_data;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdo_q    <= '0;
            buserr_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dm_req_valid = valid_q;
  assign dm_req_we    = we_q;
  assign dm_req_addr  = addr_q;
  assign dm_req_wdata = wdata_q;
  assign dm_req_wstrb = wstrb_q;
  assign MEM_rdo      = rdo_q;
  assign mem_buserr   = buserr_q;

endmodule
